// File: rtl/seg7_dynamic_driver.sv
// Purpose : time-multiplexed driver for a dynamic 7-segment display (one digit lit per slot).
// Latency : first digit appears on the period-th edge after reset release; all outputs registered.
// Backpressure: none; the scan free-runs and inputs are sampled once per frame at the digit-0 slot.
//
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   number      - packed hex value, nibble i shown on digit i (digit 0 = rightmost)
//   dots        - decimal point per digit
//   digit_en    - per-digit enable, 0 blanks that digit's slot
//   abcdefgh    - active-high segments, bit7 = a ... bit1 = g, bit0 = dot
//   digit       - active-high one-hot digit select, all-zero while blanked
//   frame_start - one-cycle pulse while digit 0 becomes active
module seg7_dynamic_driver #(
   parameter int clk_mhz    = 50,
   parameter int refresh_hz = 1000,
   parameter int w_digit    = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4*w_digit-1:0]   number,
   input  logic [w_digit-1:0]     dots,
   input  logic [w_digit-1:0]     digit_en,
   output logic [7:0]             abcdefgh,
   output logic [w_digit-1:0]     digit,
   output logic                   frame_start
);

   localparam int period = clk_mhz * 1000000 / refresh_hz;
   localparam int cw     = (period > 1) ? $clog2(period) : 1;
   localparam int iw     = (w_digit > 1) ? $clog2(w_digit) : 1;

   generate
      if (period < 1 || w_digit < 1) begin : g_bad_param
         $error("seg7_dynamic_driver: period and w_digit must both be at least 1");
      end
   endgenerate

   logic [cw-1:0]          cnt;
   logic [iw-1:0]          idx;
   logic [4*w_digit-1:0]   number_sh;
   logic [w_digit-1:0]     dots_sh;
   logic [w_digit-1:0]     en_sh;

   logic                   tick;
   logic [4*w_digit-1:0]   sel_num;
   logic [w_digit-1:0]     sel_dots;
   logic [w_digit-1:0]     sel_en;
   logic [3:0]             cur_nib;
   logic                   cur_dot;
   logic                   cur_en;
   logic [6:0]             seg;

   assign tick = (cnt == cw'(period - 1));

   // The idx-0 slot shows the values being captured on that same edge, so
   // it reads the live inputs; every other slot reads the frame snapshot.
   always_comb begin
      sel_num  = number_sh;
      sel_dots = dots_sh;
      sel_en   = en_sh;
      if (idx == '0) begin
         sel_num  = number;
         sel_dots = dots;
         sel_en   = digit_en;
      end
      cur_nib = sel_num[int'(idx)*4 +: 4];
      cur_dot = sel_dots[idx];
      cur_en  = sel_en[idx];
   end

   // Segment decode, {a,b,c,d,e,f,g}.
   always_comb begin
      seg = 7'h00;
      case (cur_nib)
         4'h0: seg = 7'h7E;
         4'h1: seg = 7'h30;
         4'h2: seg = 7'h6D;
         4'h3: seg = 7'h79;
         4'h4: seg = 7'h33;
         4'h5: seg = 7'h5B;
         4'h6: seg = 7'h5F;
         4'h7: seg = 7'h70;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h7B;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h1F;
         4'hC: seg = 7'h4E;
         4'hD: seg = 7'h3D;
         4'hE: seg = 7'h4F;
         4'hF: seg = 7'h47;
         default: seg = 7'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         idx         <= '0;
         number_sh   <= '0;
         dots_sh     <= '0;
         en_sh       <= '0;
         abcdefgh    <= '0;
         digit       <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         cnt         <= tick ? '0 : cnt + cw'(1);
         if (tick) begin
            if (idx == '0) begin
               number_sh   <= number;
               dots_sh     <= dots;
               en_sh       <= digit_en;
               frame_start <= 1'b1;
            end
            if (cur_en) begin
               digit    <= w_digit'(1) << idx;
               abcdefgh <= {seg, cur_dot};
            end else begin
               // Blanked slot still takes its dwell time; dot suppressed too.
               digit    <= '0;
               abcdefgh <= '0;
            end
            idx <= (idx == iw'(w_digit - 1)) ? '0 : idx + iw'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg7_dynamic_driver.sv
module tb_seg7_dynamic_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] number = 24'h0;
   logic [5:0]  dots = 6'h0;
   logic [5:0]  digit_en = 6'h0;
   logic [7:0]  abcdefgh;
   logic [5:0]  digit;
   logic        frame_start;

   int total = 0;
   int bad   = 0;

   seg7_dynamic_driver #(
      .clk_mhz    (1),
      .refresh_hz (250000),
      .w_digit    (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .number      (number),
      .dots        (dots),
      .digit_en    (digit_en),
      .abcdefgh    (abcdefgh),
      .digit       (digit),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Releases reset between edges and checks the startup sequence; returns
   // sampled just after the first tick edge (slot 0 of the first frame).
   task automatic startup_seq(input string name, input logic [7:0] seg0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         step();
         total++;
         if ({digit, abcdefgh, frame_start} !== 15'h0) begin
            bad++;
            $display("FAIL %s idle edge %0d: got digit=%b seg=%h fs=%b, need all zero",
                     name, e, digit, abcdefgh, frame_start);
         end
      end
      step();
      total++;
      if ({digit, abcdefgh, frame_start} !== {6'b000001, seg0, 1'b1}) begin
         bad++;
         $display("FAIL %s first tick: got digit=%b seg=%h fs=%b, need 000001/%h/1",
                  name, digit, abcdefgh, frame_start, seg0);
      end
   endtask

   task automatic test_reset();
      number   = 24'h012345;
      dots     = 6'h00;
      digit_en = 6'h3F;
      rst_n    = 1'b0;
      step();
      step();
      total++;
      if ({digit, abcdefgh, frame_start} !== 15'h0) begin
         bad++;
         $display("FAIL reset_hold: got digit=%b seg=%h fs=%b, need all zero",
                  digit, abcdefgh, frame_start);
      end
      startup_seq("startup", 8'hB6);
   endtask

   // Starts sampled at a slot-0 tick; checks a whole frame, ends at the next slot-0 tick.
   task automatic check_frame(input string name, input logic [5:0] exp_dig [6],
                              input logic [7:0] exp_seg [6]);
      for (int s = 0; s < 6; s++) begin
         for (int c = 0; c < 4; c++) begin
            total++;
            if ({digit, abcdefgh, frame_start} !==
                {exp_dig[s], exp_seg[s], (s == 0 && c == 0)}) begin
               bad++;
               $display("FAIL %s slot %0d cyc %0d: got digit=%b seg=%h fs=%b, need %b/%h/%b",
                        name, s, c, digit, abcdefgh, frame_start,
                        exp_dig[s], exp_seg[s], (s == 0 && c == 0));
            end
            step();
         end
      end
   endtask

   task automatic test_scan();
      logic [5:0] d [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
      logic [7:0] g [6] = '{8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC};
      check_frame("scan", d, g);
      total++;
      if ({digit, abcdefgh, frame_start} !== {6'b000001, 8'hB6, 1'b1}) begin
         bad++;
         $display("FAIL scan_wrap: got digit=%b seg=%h fs=%b, need 000001/b6/1",
                  digit, abcdefgh, frame_start);
      end
   endtask

   task automatic test_snapshot();
      logic [5:0] d [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
      logic [7:0] old_seg [6] = '{8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC};
      logic [7:0] f [6] = '{8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E};
      for (int i = 0; i < 8; i++) step();
      total++;
      if (digit !== 6'b000100) begin
         bad++;
         $display("FAIL snap_pos: got digit=%b, need 000100", digit);
      end
      number = 24'hFFFFFF;
      for (int s = 2; s < 6; s++) begin
         for (int c = 0; c < 4; c++) begin
            total++;
            if ({digit, abcdefgh} !== {d[s], old_seg[s]}) begin
               bad++;
               $display("FAIL snap_old slot %0d cyc %0d: got %b/%h, need %b/%h",
                        s, c, digit, abcdefgh, d[s], old_seg[s]);
            end
            step();
         end
      end
      check_frame("snap_new", d, f);
   endtask

   task automatic test_mask_dots();
      logic [5:0] d [6] = '{6'b000001, 6'b000010, 6'b000000, 6'b001000, 6'b010000, 6'b100000};
      logic [7:0] g [6] = '{8'hB7, 8'hFC, 8'h00, 8'hFC, 8'hFC, 8'hFC};
      number   = 24'h000005;
      dots     = 6'b000101;
      digit_en = 6'b111011;
      for (int i = 0; i < 24; i++) step();
      check_frame("mask_dots", d, g);
   endtask

   task automatic test_hex();
      logic [5:0] d [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
      logic [7:0] g1 [6] = '{8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE};
      logic [7:0] g2 [6] = '{8'hF6, 8'hFE, 8'hE0, 8'hBE, 8'hFC, 8'hFC};
      number   = 24'hABCDEF;
      dots     = 6'h00;
      digit_en = 6'h3F;
      for (int i = 0; i < 24; i++) step();
      check_frame("hex_af", d, g1);
      number = 24'h006789;
      for (int i = 0; i < 24; i++) step();
      check_frame("hex_69", d, g2);
   endtask

   task automatic test_midframe_reset();
      for (int i = 0; i < 12; i++) step();
      total++;
      if (digit !== 6'b001000) begin
         bad++;
         $display("FAIL mid_pos: got digit=%b, need 001000", digit);
      end
      step();
      rst_n = 1'b0;
      #1;
      total++;
      if ({digit, abcdefgh, frame_start} !== 15'h0) begin
         bad++;
         $display("FAIL mid_async_reset: got digit=%b seg=%h fs=%b, need all zero",
                  digit, abcdefgh, frame_start);
      end
      step();
      step();
      startup_seq("restart", 8'hF6);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_snapshot();
      test_mask_dots();
      test_hex();
      test_midframe_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_dynamic_driver.md
Name: seg7_dynamic_driver

Overview:
- Time-multiplexed driver for a dynamic seven-segment display. It produces the one-hot `digit` select and `abcdefgh` segment bus that the board top converts into static HEX0..HEX5 outputs.
- It takes a packed hex number, per-digit decimal points and a per-digit enable mask, snapshots them once per scan frame, and cycles through digits at a fixed dwell rate.
- It sits between lab logic (for example the adder result) and the board-level 7-segment adaptation.

Parameters:
- clk_mhz, 50, clock frequency in MHz.
- refresh_hz, 1000, digit advance rate in Hz; period = clk_mhz*1_000_000/refresh_hz cycles; elaboration must fail if period < 1.
- w_digit, 6, number of digit positions, ≥1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- number, input, 4*w_digit, nibble i = number[4i+3:4i], shown on digit i; digit 0 is rightmost (HEX0).
- dots, input, w_digit, decimal point for digit i.
- digit_en, input, w_digit, 1 = digit i lit, 0 = digit i blanked.
- abcdefgh, output, 8, active-high segments, bit7 = a … bit1 = g, bit0 = h (dot).
- digit, output, w_digit, active-high one-hot select, or all-zero when blank.
- frame_start, output, 1, one-cycle pulse while digit 0 becomes active.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-frame): immediately sets abcdefgh = 0, digit = 0, frame_start = 0. It also clears the dwell counter, next index and shadow registers to 0.
- Dwell counter: counts 0..period-1 and wraps. A tick occurs in the cycle where counter == period-1. With period = 1, every cycle is a tick.
- After reset release, outputs stay all-zero until the first tick. The first rising edge with tick shows digit index 0, so outputs change on the period-th edge after release.
- On each tick edge, with idx = next index:
  - idx == 0: number, dots and digit_en are captured into the shadow registers, and the freshly captured values drive this slot. frame_start <= 1.
  - Otherwise frame_start <= 0, and frame_start is also 0 on every non-tick edge.
  - digit_en_shadow[idx] = 1: digit <= 1<<idx; abcdefgh <= {seg(nibble idx), dots_shadow[idx]}.
  - digit_en_shadow[idx] = 0: digit <= 0 and abcdefgh <= 0. The slot time is still consumed and the dot is suppressed.
  - next index <= (idx == w_digit-1) ? 0 : idx+1.
- Between ticks, outputs hold their value.
- Input changes mid-frame have no visible effect until the next frame's idx-0 tick (no tearing).
- seg() values for {a..g,0}, by nibble:
  - 0: FC; 1: 60; 2: DA; 3: F2
  - 4: 66; 5: B6; 6: BE; 7: E0
  - 8: FE; 9: F6; A: EE; b: 3E
  - C: 9C; d: 7A; E: 9E; F: 8E
- Frame length is w_digit*period cycles. A single-digit build (w_digit = 1) pulses frame_start on every tick.
- No combinational path from inputs to outputs.

Test Plan:
- All scenarios use clk_mhz = 1, refresh_hz = 250_000 (period = 4), w_digit = 6.
- Reset/startup: hold rst_n = 0, then release. Required: digit = 0, abcdefgh = 0, frame_start = 0 for 3 edges; on the 4th edge digit = 000001 and frame_start = 1 for exactly one cycle.
- Scan order: number = 24'h012345, dots = 0, digit_en = 6'h3F. Required digit/abcdefgh pairs, each held 4 cycles:
  - 000001/B6
  - 000010/66
  - 000100/F2
  - 001000/DA
  - 010000/60
  - 100000/FC
  - then 000001/B6 with frame_start = 1.
- Snapshot: while digit = 000100, change number to 24'hFFFFFF. Required: the remaining slots still show DA, 60, FC; the next frame shows 8E on all digits.
- Mask and dots: number = 24'h000005, dots = 6'b000101, digit_en = 6'b111011. Required:
  - slot 0 abcdefgh = B7;
  - slot 2 digit = 0 and abcdefgh = 0 for 4 cycles;
  - slot 1 abcdefgh = FC.
- Hex coverage: number = 24'hABCDEF. Required per slot: 8E, 9E, 7A, 9C, 3E, EE.
- Mid-frame reset: pull rst_n low while digit = 001000. Required: outputs are 0 in the same cycle, without waiting for a clock edge; after release, restart as in the startup scenario with digit 0 first.
